// File: rtl/stack_cmd_if.sv
// Command/response bus of the stack command sequencer.
// The master side issues push/pop commands and takes pop responses.
// The slave side is the sequencer.
interface stack_cmd_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_pop;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    modport master (
        output cmd_valid, cmd_pop, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_pop, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/stack_cmd_sequencer.sv
// Command front-end for the LIFO stack: takes push/pop commands over a valid/ready
// handshake, issues at most one stack strobe per cycle, tracks depth, rejects
// push-on-full / pop-on-empty with sticky error flags and returns popped data on a
// valid/ready response channel.
// Optional build macro STACK_CMD_WRAP_EN: push-on-full is issued anyway (the stack
// overwrites its oldest entry), depth stays at DEPTH and ovf_err is raised as a warning.
module stack_cmd_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DEPTH_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    stack_cmd_if.slave            bus,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [DATA_WIDTH-1:0] stk_value,
    input  logic [DATA_WIDTH-1:0] stk_output,
    output logic [DEPTH_W-1:0]    depth,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf_err,
    output logic                  unf_err,
    input  logic                  err_clr
);

`ifdef STACK_CMD_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state;
    logic                  op_pop;
    logic                  cmd_ready_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    logic                  rsp_err_r;
    logic                  stk_push_r;
    logic                  stk_pop_r;
    logic [DATA_WIDTH-1:0] stk_value_r;
    logic [DEPTH_W-1:0]    depth_r;
    logic                  ovf_r;
    logic                  unf_r;
    logic                  full_w;
    logic                  empty_w;
    logic                  ovf_set;
    logic                  unf_set;

    assign full_w  = (depth_r == DEPTH_MAX);
    assign empty_w = (depth_r == '0);

    // Rejections are resolved in ISSUE; depth is stable from accept until the end of ISSUE.
    assign ovf_set = (state == ISSUE) && !op_pop && full_w;
    assign unf_set = (state == ISSUE) && op_pop && empty_w;

    // Sequencer FSM with all outputs registered; strobes are decided at accept so ISSUE
    // drives clean flop outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_pop      <= 1'b0;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
            stk_push_r  <= 1'b0;
            stk_pop_r   <= 1'b0;
            stk_value_r <= '0;
            depth_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_r) begin
                        state       <= ISSUE;
                        cmd_ready_r <= 1'b0;
                        op_pop      <= bus.cmd_pop;
                        if (bus.cmd_pop) begin
                            stk_pop_r <= !empty_w;
                        end else if (!full_w || WRAP_EN) begin
                            stk_push_r  <= 1'b1;
                            stk_value_r <= bus.cmd_data;
                        end
                    end
                end
                ISSUE: begin
                    stk_push_r  <= 1'b0;
                    stk_pop_r   <= 1'b0;
                    stk_value_r <= '0;
                    if (op_pop) begin
                        state       <= RESP;
                        rsp_valid_r <= 1'b1;
                        if (!empty_w) begin
                            rsp_data_r <= stk_output;
                            rsp_err_r  <= 1'b0;
                            depth_r    <= depth_r - DEPTH_W'(1);
                        end else begin
                            rsp_data_r <= '0;
                            rsp_err_r  <= 1'b1;
                        end
                    end else begin
                        state       <= IDLE;
                        cmd_ready_r <= 1'b1;
                        // A wrapping push leaves depth saturated at DEPTH.
                        if (!full_w) begin
                            depth_r <= depth_r + DEPTH_W'(1);
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Sticky error flags; a new rejection wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_set || (ovf_r && !err_clr);
            unf_r <= unf_set || (unf_r && !err_clr);
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign stk_push      = stk_push_r;
    assign stk_pop       = stk_pop_r;
    assign stk_value     = stk_value_r;
    assign depth         = depth_r;
    assign full          = full_w;
    assign empty         = empty_w;
    assign ovf_err       = ovf_r;
    assign unf_err       = unf_r;

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Bench for stack_cmd_sequencer: a directed vector table, a full/overflow sequence,
// randomized commands against a queue-based LIFO model, and a mid-ISSUE reset.
`timescale 1ns/1ps
module tb_stack_cmd_sequencer;
    localparam int unsigned DW      = 8;
    localparam int unsigned DEPTH   = 32;
    localparam int unsigned DEPTH_W = 6;
`ifdef STACK_CMD_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               err_clr = 1'b0;
    logic               stk_push;
    logic               stk_pop;
    logic [DW-1:0]      stk_value;
    logic [DW-1:0]      stk_output;
    logic [DEPTH_W-1:0] depth;
    logic               full;
    logic               empty;
    logic               ovf_err;
    logic               unf_err;

    stack_cmd_if #(.DATA_WIDTH(DW)) bus ();

    stack_cmd_sequencer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .DEPTH_W   (DEPTH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_value (stk_value),
        .stk_output(stk_output),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Stand-in for the real stack: RAM plus a wrapping pointer, sharing rst.
    logic [DW-1:0] stk_mem [DEPTH];
    logic [4:0]    sp;
    logic [4:0]    sp_top;
    assign sp_top     = sp - 5'd1;
    assign stk_output = stk_pop ? stk_mem[sp_top] : '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (stk_push) begin
            stk_mem[sp] <= stk_value;
            sp          <= sp + 5'd1;
        end else if (stk_pop) begin
            sp <= sp_top;
        end
    end

    // Reference model: stack contents oldest-first plus sticky flags.
    logic [7:0] model_q[$];
    bit         m_ovf;
    bit         m_unf;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: cmd_ready got %b expected 1", bus.cmd_ready);
        end
    endtask

    task automatic chk_flags();
        chk("depth", depth, model_q.size());
        chk("full", full, model_q.size() == DEPTH);
        chk("empty", empty, model_q.size() == 0);
        chk("ovf_err", ovf_err, m_ovf);
        chk("unf_err", unf_err, m_unf);
    endtask

    // One complete command; called and returning on a falling edge.
    task automatic do_cmd(input bit pop, input logic [7:0] data, input int hold, input bit clr,
                          output logic [7:0] got_data, output bit got_err);
        bit         legal;
        logic [7:0] exp_data = 8'h00;
        int         sz;
        got_data = 8'h00;
        got_err  = 1'b0;
        wait_idle();
        sz = model_q.size();
        bus.cmd_valid = 1'b1;
        bus.cmd_pop   = pop;
        bus.cmd_data  = data;
        @(negedge clk);
        // ISSUE cycle
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'($urandom);
        err_clr       = clr;
        if (!pop) begin
            legal = (sz < DEPTH) || WRAP;
            chk("issue_push", stk_push, legal);
            chk("issue_pop_quiet", stk_pop, 0);
            chk("issue_value", stk_value, legal ? data : 8'h00);
        end else begin
            legal    = sz > 0;
            exp_data = legal ? model_q[sz-1] : 8'h00;
            chk("issue_pop", stk_pop, legal);
            chk("issue_push_quiet", stk_push, 0);
            chk("issue_value_zero", stk_value, 0);
        end
        chk("issue_ready_low", bus.cmd_ready, 0);
        chk("issue_rsp_low", bus.rsp_valid, 0);
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (!pop) begin
            if (sz == DEPTH) m_ovf = 1'b1;
            if (sz < DEPTH) begin
                model_q.push_back(data);
            end else if (WRAP) begin
                void'(model_q.pop_front());
                model_q.push_back(data);
            end
        end else if (legal) begin
            void'(model_q.pop_back());
        end else begin
            m_unf = 1'b1;
        end
        @(negedge clk);
        err_clr = 1'b0;
        chk_flags();
        if (pop) begin
            for (int i = 0; i <= hold; i++) begin
                chk("rsp_valid", bus.rsp_valid, 1);
                chk("rsp_data", bus.rsp_data, exp_data);
                chk("rsp_err", bus.rsp_err, !legal);
                chk("resp_ready_low", bus.cmd_ready, 0);
                if (i == 0) begin
                    got_data = bus.rsp_data;
                    got_err  = bus.rsp_err;
                end
                if (i == hold) bus.rsp_ready = 1'b1;
                @(negedge clk);
            end
            bus.rsp_ready = 1'b0;
            chk("rsp_done", bus.rsp_valid, 0);
        end
        chk("back_idle", bus.cmd_ready, 1);
    endtask

    task automatic clear_errs();
        wait_idle();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        chk("clr_ovf", ovf_err, 0);
        chk("clr_unf", unf_err, 0);
    endtask

    typedef struct {
        bit         pop;
        logic [7:0] data;
        int         hold;
        bit         clr;
        logic [7:0] exp_data;
        bit         exp_err;
        int         exp_depth;
    } vec_t;

    initial begin
        vec_t       vecs[10];
        logic [7:0] gd;
        bit         ge;
        int         pct;

        vecs[0] = '{0, 8'hA5, 0, 0, 8'h00, 0, 1};
        vecs[1] = '{1, 8'h00, 0, 0, 8'hA5, 0, 0};
        vecs[2] = '{1, 8'h00, 0, 0, 8'h00, 1, 0};
        vecs[3] = '{0, 8'h3C, 0, 0, 8'h00, 0, 1};
        vecs[4] = '{0, 8'h7E, 0, 0, 8'h00, 0, 2};
        vecs[5] = '{1, 8'h00, 5, 0, 8'h7E, 0, 1};
        vecs[6] = '{1, 8'h00, 0, 1, 8'h3C, 0, 0};
        vecs[7] = '{1, 8'h00, 1, 1, 8'h00, 1, 0};
        vecs[8] = '{0, 8'h11, 0, 0, 8'h00, 0, 1};
        vecs[9] = '{1, 8'h00, 2, 0, 8'h11, 0, 0};

        bus.cmd_valid = 1'b0;
        bus.cmd_pop   = 1'b0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_flags();
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_push", stk_push, 0);
        chk("rst_pop", stk_pop, 0);

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            do_cmd(vecs[i].pop, vecs[i].data, vecs[i].hold, vecs[i].clr, gd, ge);
            if (vecs[i].pop) begin
                chk("vec_data", gd, vecs[i].exp_data);
                chk("vec_err", ge, vecs[i].exp_err);
            end
            chk("vec_depth", depth, vecs[i].exp_depth);
        end
        chk("vec_unf_sticky", unf_err, 1);
        clear_errs();

        // Fill to full, one push past full, then drain
        for (int i = 0; i < DEPTH; i++) do_cmd(1'b0, 8'(i), 0, 1'b0, gd, ge);
        chk("fill_full", full, 1);
        chk("fill_depth", depth, DEPTH);
        do_cmd(1'b0, 8'hFF, 0, 1'b0, gd, ge);
        chk("over_ovf", ovf_err, 1);
        chk("over_depth", depth, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            do_cmd(1'b1, 8'h00, 0, 1'b0, gd, ge);
            if (i == 0) chk("drain_first", gd, WRAP ? 8'hFF : 8'd31);
            if (i == DEPTH - 1) chk("drain_last", gd, WRAP ? 8'd1 : 8'd0);
        end
        chk("drain_empty", empty, 1);
        clear_errs();

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            pct = (model_q.size() > 28) ? 70 : (model_q.size() < 3) ? 30 : 50;
            do_cmd($urandom_range(0, 99) < pct, 8'($urandom), int'($urandom_range(0, 3)),
                   $urandom_range(0, 7) == 0, gd, ge);
            if ($urandom_range(0, 15) == 0) clear_errs();
        end

        // Reset during the ISSUE cycle of a pop
        do_cmd(1'b0, 8'h42, 0, 1'b0, gd, ge);
        wait_idle();
        bus.cmd_valid = 1'b1;
        bus.cmd_pop   = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("midrst_pop_before", stk_pop, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_pop_drop", stk_pop, 0);
        chk("midrst_rsp", bus.rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", bus.rsp_valid, 0);
            chk("midrst_ready", bus.cmd_ready, 1);
        end
        chk_flags();
        do_cmd(1'b1, 8'h00, 0, 1'b0, gd, ge);
        chk("midrst_then_empty_pop", ge, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
